// File: rtl/mp64_extmem.sv
// mp64_extmem: 64-bit request port to a 16-bit async SRAM, issued as little-endian beats.
// Define MP64_EXTMEM_RANGE_CHK_EN to fault requests above ADDR_W instead of aliasing them.
//
//   state    | meaning
//   S_IDLE   | waiting for ext_req; request fields latched on acceptance
//   S_ACCESS | driving beats of WAIT_CYCLES clocks each to the device
//   S_ACK    | one-cycle ext_ack; ext_req ignored here
module mp64_extmem #(
  parameter int ADDR_W      = 24,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_req,
  input  logic [63:0]       ext_addr,
  input  logic [63:0]       ext_wdata,
  input  logic              ext_wen,
  input  logic [1:0]        ext_size,
  output logic [63:0]       ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-2:0] sram_a,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [1:0]        sram_be_n
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-2:0] r_base;
  logic              r_lsb;
  logic              r_wen;
  logic [1:0]        r_size;
  logic [63:0]       r_wdata;
  logic [1:0]        r_beat;
  logic [3:0]        r_wait;
  logic [63:0]       r_rbuf;

  logic [63:0] w_aligned;
  logic        w_oor;
  logic        w_unused_bits;
  logic [1:0]  w_last_beat;
  logic        w_beat_done;
  logic        w_last;
  logic        w_acc;
  logic [63:0] w_rnext;
  logic [63:0] w_rfinal;
  logic [15:0] w_dq;

  assign w_aligned     = ext_addr & ~((64'd1 << ext_size) - 64'd1);
  assign w_unused_bits = ^{w_aligned[63:ADDR_W], w_aligned[0]};

`ifdef MP64_EXTMEM_RANGE_CHK_EN
  assign w_oor = |ext_addr[63:ADDR_W];
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_last_beat = 2'd0;
    case (r_size)
      2'd3:    w_last_beat = 2'd3;
      2'd2:    w_last_beat = 2'd1;
      default: w_last_beat = 2'd0;
    endcase
  end

  assign w_beat_done = (r_wait == 4'd0);
  assign w_last      = w_beat_done && (r_beat == w_last_beat);
  assign w_acc       = (r_state == S_ACCESS);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ext_req) w_next = w_oor ? S_ACK : S_ACCESS;
      S_ACCESS: if (w_last) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Read lanes assembled in place; the final beat is merged straight from the bus.
  always_comb begin
    w_rnext = r_rbuf;
    case (r_beat)
      2'd0:    w_rnext[15:0]  = sram_dq_i;
      2'd1:    w_rnext[31:16] = sram_dq_i;
      2'd2:    w_rnext[47:32] = sram_dq_i;
      default: w_rnext[63:48] = sram_dq_i;
    endcase
  end

  always_comb begin
    w_rfinal = 64'd0;
    case (r_size)
      2'd0:    w_rfinal[7:0]  = r_lsb ? w_rnext[15:8] : w_rnext[7:0];
      2'd1:    w_rfinal[15:0] = w_rnext[15:0];
      2'd2:    w_rfinal[31:0] = w_rnext[31:0];
      default: w_rfinal       = w_rnext;
    endcase
  end

  always_comb begin
    w_dq = r_wdata[63:48];
    if (r_size == 2'd0) begin
      w_dq = {r_wdata[7:0], r_wdata[7:0]};
    end else begin
      case (r_beat)
        2'd0:    w_dq = r_wdata[15:0];
        2'd1:    w_dq = r_wdata[31:16];
        2'd2:    w_dq = r_wdata[47:32];
        default: w_dq = r_wdata[63:48];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_lsb     <= 1'b0;
      r_wen     <= 1'b0;
      r_size    <= 2'd0;
      r_wdata   <= '0;
      r_beat    <= 2'd0;
      r_wait    <= 4'd0;
      r_rbuf    <= '0;
      ext_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (ext_req) begin
            r_base  <= w_aligned[ADDR_W-1:1];
            r_lsb   <= ext_addr[0];
            r_wen   <= ext_wen;
            r_size  <= ext_size;
            r_wdata <= ext_wdata;
            r_beat  <= 2'd0;
            r_wait  <= WAIT_LAST;
            if (w_oor && !ext_wen) ext_rdata <= '1;
          end
        end
        S_ACCESS: begin
          if (w_beat_done) begin
            if (!r_wen) r_rbuf <= w_rnext;
            if (w_last) begin
              if (!r_wen) ext_rdata <= w_rfinal;
            end else begin
              r_beat <= r_beat + 2'd1;
              r_wait <= WAIT_LAST;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes derive only from state so an async reset releases the bus at once.
  assign ext_ack    = (r_state == S_ACK);
  assign sram_a     = r_base + (ADDR_W-1)'(r_beat);
  assign sram_dq_o  = w_dq;
  assign sram_ce_n  = ~w_acc;
  assign sram_oe_n  = ~(w_acc & ~r_wen);
  assign sram_dq_oe = w_acc & r_wen;
  assign sram_we_n  = ~(w_acc & r_wen & ~w_beat_done);
  assign sram_be_n  = !w_acc ? 2'b11 :
                      (r_size != 2'd0) ? 2'b00 :
                      (r_lsb ? 2'b01 : 2'b10);

endmodule

// File: tb/tb_mp64_extmem.sv
// Scoreboard bench for mp64_extmem with a 16-bit SRAM model; honours MP64_EXTMEM_RANGE_CHK_EN.
module tb_mp64_extmem;

  localparam int ADDR_W = 24;
  localparam int WAIT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_req = 1'b0;
  logic [63:0] ext_addr = '0;
  logic [63:0] ext_wdata = '0;
  logic        ext_wen = 1'b0;
  logic [1:0]  ext_size = 2'd0;
  logic [63:0] ext_rdata;
  logic        ext_ack;
  logic [ADDR_W-2:0] sram_a;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;

  logic [15:0] mem [0:1023];

  mp64_extmem #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_wen(ext_wen), .ext_size(ext_size),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_i = mem[sram_a[9:0]];

  typedef struct {logic [22:0] a; logic [15:0] dq; logic [1:0] be; logic wr;} beat_t;
  typedef struct {logic [63:0] rdata; int ack_edge;} resp_t;

  beat_t exp_beats[$];
  resp_t exp_resp[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string got, input string want);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s expected %s", name, got, want);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Device model: byte-enabled write while we_n is low.
  initial forever begin
    @(negedge clk);
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_a[9:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_be_n[1]) mem[sram_a[9:0]][15:8] = sram_dq_o[15:8];
    end
  end

  // Beat monitor: checks address/lanes at beat start, strobe timing at beat end.
  initial begin
    logic        in_beat;
    logic [22:0] cur_a;
    logic        cur_wr;
    int          ce_cnt, we_cnt;
    beat_t       b;
    in_beat = 1'b0;
    cur_a = '0;
    cur_wr = 1'b0;
    ce_cnt = 0;
    we_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_beat = 1'b0;
      end else if (!sram_ce_n) begin
        if (!in_beat || sram_a != cur_a) begin
          if (in_beat) begin
            chk("beat_len", 64'(ce_cnt), 64'(WAIT));
            chk("beat_we_len", 64'(we_cnt), cur_wr ? 64'(WAIT - 1) : 64'd0);
          end
          if (exp_beats.size() == 0) begin
            fail_evt("beat_unexpected", $sformatf("beat at a=%h", sram_a), "no beat");
            cur_wr = ~sram_dq_oe;
          end else begin
            b = exp_beats.pop_front();
            chk("beat_a", 64'(sram_a), 64'(b.a));
            chk("beat_be_n", 64'(sram_be_n), 64'(b.be));
            chk("beat_dq_oe", 64'(sram_dq_oe), 64'(b.wr));
            chk("beat_oe_n", 64'(sram_oe_n), 64'(b.wr));
            if (b.wr) chk("beat_dq_o", 64'(sram_dq_o), 64'(b.dq));
            cur_wr = b.wr;
          end
          cur_a = sram_a;
          ce_cnt = 0;
          we_cnt = 0;
          in_beat = 1'b1;
        end
        ce_cnt++;
        if (!sram_we_n) we_cnt++;
      end else if (in_beat) begin
        chk("beat_len", 64'(ce_cnt), 64'(WAIT));
        chk("beat_we_len", 64'(we_cnt), cur_wr ? 64'(WAIT - 1) : 64'd0);
        in_beat = 1'b0;
      end
    end
  end

  // Ack monitor: ack_edge is the clock edge at which ack is first sampled high.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && ext_ack) begin
        if (exp_resp.size() == 0) begin
          fail_evt("ack_unexpected", $sformatf("ack at edge %0d", cyc + 1), "no ack");
        end else begin
          r = exp_resp.pop_front();
          chk("ack_edge", 64'(cyc + 1), 64'(r.ack_edge));
          chk("ack_rdata", ext_rdata, r.rdata);
        end
      end
    end
  end

  // Called at a negedge; lat = clocks from accepting edge to the edge that samples ack.
  task automatic do_req(input logic [63:0] addr, input logic [63:0] wdata, input logic wen,
                        input logic [1:0] size, input logic [22:0] a0, input int nb,
                        input logic [1:0] be, input logic [63:0] dq, input logic [63:0] rdata,
                        input int lat, input bit hold);
    beat_t b;
    resp_t r;
    bit    got;
    ext_addr = addr;
    ext_wdata = wdata;
    ext_wen = wen;
    ext_size = size;
    ext_req = 1'b1;
    for (int k = 0; k < nb; k++) begin
      b.a = a0 + 23'(k);
      b.dq = dq[16*k +: 16];
      b.be = be;
      b.wr = wen;
      exp_beats.push_back(b);
    end
    r.rdata = rdata;
    r.ack_edge = cyc + 1 + lat;
    exp_resp.push_back(r);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ext_ack) begin
        got = 1'b1;
      end else begin
        ext_addr = ~addr;
        ext_wdata = ~wdata;
        ext_wen = ~wen;
        ext_size = ~size;
      end
    end
    if (!got) begin
      fail_evt("ack_timeout", "no ack in 100 clocks", "ack");
      exp_beats.delete();
      exp_resp.delete();
    end
    if (!hold) ext_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit got;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0]      = 16'h1234;
    mem[10'h100] = 16'h0708;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ext_ack), 64'd0);
    chk("rst_rdata", ext_rdata, 64'd0);
    chk("rst_sram_a", 64'(sram_a), 64'd0);
    chk("rst_dq_o", 64'(sram_dq_o), 64'd0);
    chk("rst_dq_oe", 64'(sram_dq_oe), 64'd0);
    chk("rst_ce_n", 64'(sram_ce_n), 64'd1);
    chk("rst_oe_n", 64'(sram_oe_n), 64'd1);
    chk("rst_we_n", 64'(sram_we_n), 64'd1);
    chk("rst_be_n", 64'(sram_be_n), 64'd3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(64'h100, 64'h1122_3344_5566_7788, 1'b1, 2'd3, 23'h80, 4, 2'b00,
           64'h1122_3344_5566_7788, 64'd0, 9, 1'b0);
    do_req(64'h100, 64'd0, 1'b0, 2'd3, 23'h80, 4, 2'b00, 64'd0,
           64'h1122_3344_5566_7788, 9, 1'b0);
    do_req(64'h201, 64'd0, 1'b0, 2'd0, 23'h100, 1, 2'b01, 64'd0, 64'h07, 3, 1'b0);
    do_req(64'h200, 64'd0, 1'b0, 2'd1, 23'h100, 1, 2'b00, 64'd0, 64'h0708, 3, 1'b0);
    do_req(64'h201, 64'd0, 1'b0, 2'd1, 23'h100, 1, 2'b00, 64'd0, 64'h0708, 3, 1'b0);
    do_req(64'h303, 64'h9999_9999_AABB_CCDD, 1'b1, 2'd2, 23'h180, 2, 2'b00,
           64'h0000_0000_AABB_CCDD, 64'h0708, 5, 1'b0);
    do_req(64'h302, 64'd0, 1'b0, 2'd2, 23'h180, 2, 2'b00, 64'd0, 64'hAABB_CCDD, 5, 1'b0);
    do_req(64'h305, 64'h1234_5678_9ABC_DE5A, 1'b1, 2'd0, 23'h182, 1, 2'b01,
           64'h5A5A, 64'hAABB_CCDD, 3, 1'b0);
    do_req(64'h304, 64'h0000_0000_0000_00C3, 1'b1, 2'd0, 23'h182, 1, 2'b10,
           64'hC3C3, 64'hAABB_CCDD, 3, 1'b0);
    do_req(64'h304, 64'd0, 1'b0, 2'd2, 23'h182, 2, 2'b00, 64'd0, 64'h5AC3, 5, 1'b0);
    do_req(64'h304, 64'd0, 1'b0, 2'd0, 23'h182, 1, 2'b10, 64'd0, 64'hC3, 3, 1'b0);
    // Request held through the ack cycle, then a new one issued with no gap.
    do_req(64'h200, 64'd0, 1'b0, 2'd1, 23'h100, 1, 2'b00, 64'd0, 64'h0708, 3, 1'b1);
    do_req(64'h201, 64'd0, 1'b0, 2'd0, 23'h100, 1, 2'b01, 64'd0, 64'h07, 3, 1'b0);
`ifdef MP64_EXTMEM_RANGE_CHK_EN
    do_req(64'h1_0000_0000, 64'd0, 1'b0, 2'd1, 23'h0, 0, 2'b00, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
`else
    do_req(64'h1_0000_0000, 64'd0, 1'b0, 2'd1, 23'h0, 1, 2'b00, 64'd0, 64'h1234, 3, 1'b0);
`endif

    // Reset during beat 2 of a dword write.
    ext_addr = 64'h400;
    ext_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    ext_wen = 1'b1;
    ext_size = 2'd3;
    ext_req = 1'b1;
    exp_beats.push_back('{a: 23'h200, dq: 16'hDDDD, be: 2'b00, wr: 1'b1});
    exp_beats.push_back('{a: 23'h201, dq: 16'hCCCC, be: 2'b00, wr: 1'b1});
    exp_beats.push_back('{a: 23'h202, dq: 16'hBBBB, be: 2'b00, wr: 1'b1});
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (!sram_ce_n && sram_a == 23'h202) got = 1'b1;
    end
    if (!got) fail_evt("beat2_timeout", "beat 2 not seen", "beat 2");
    #2;
    rst_n = 1'b0;
    ext_req = 1'b0;
    #1;
    chk("abort_ce_n", 64'(sram_ce_n), 64'd1);
    chk("abort_we_n", 64'(sram_we_n), 64'd1);
    chk("abort_oe_n", 64'(sram_oe_n), 64'd1);
    chk("abort_dq_oe", 64'(sram_dq_oe), 64'd0);
    chk("abort_be_n", 64'(sram_be_n), 64'd3);
    chk("abort_ack", 64'(ext_ack), 64'd0);
    exp_beats.delete();
    exp_resp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_req(64'h100, 64'd0, 1'b0, 2'd3, 23'h80, 4, 2'b00, 64'd0,
           64'h1122_3344_5566_7788, 9, 1'b0);

    repeat (5) @(negedge clk);
    chk("beats_left", 64'(exp_beats.size()), 64'd0);
    chk("resp_left", 64'(exp_resp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mp64_extmem.md
MP64_EXTMEM -- requirements
Module: mp64_extmem

Interface
REQ-001 Parameter: ADDR_W, default 24, byte-address width of the external device (16 MiB).
REQ-002 Parameter: WAIT_CYCLES, default 2, clocks per 16-bit beat; legal range 2..15.
REQ-003 clk  in  1  single clock for the block.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ext_req  in  1  request from mp64_memory; held high until ext_ack is sampled.
REQ-006 ext_addr  in  64  byte address.
REQ-007 ext_wdata  in  64  write data, right-justified.
REQ-008 ext_wen  in  1  1=write, 0=read.
REQ-009 ext_size  in  2  BUS_BYTE/BUS_HALF/BUS_WORD/BUS_DWORD (0..3).
REQ-010 ext_rdata  out  64  read data, right-justified, zero-extended.
REQ-011 ext_ack  out  1  one-cycle completion pulse.
REQ-012 sram_a  out  ADDR_W-1  halfword address to the device.
REQ-013 sram_dq_o / sram_dq_i / sram_dq_oe  out/in/out  16/16/1  data bus and drive enable.
REQ-014 sram_ce_n / sram_oe_n / sram_we_n  out  1 each  active-low strobes.
REQ-015 sram_be_n  out  2  active-low byte enables; bit0 = dq[7:0] = lower byte address.

Function
REQ-016 The block shall be the responder for the mp64_memory external port, converting each request into 16-bit little-endian beats.
REQ-017 FSM states IDLE, ACCESS, ACK; IDLE->ACCESS on ext_req=1 sampled in IDLE; ACCESS->ACK after the last beat; ACK->IDLE unconditionally.
REQ-018 On acceptance, address, wdata, wen and size shall be latched; later input changes are ignored until ack.
REQ-019 Address bits below the access size shall be ignored (aligned down).
REQ-020 Beat count: byte=1, half=1, word=2, dword=4; beat k drives sram_a = aligned_addr[ADDR_W-1:1] + k.
REQ-021 Each beat shall last exactly WAIT_CYCLES clocks with sram_ce_n=0; reads assert sram_oe_n=0 for the whole beat; writes assert sram_dq_oe=1 for the whole beat and sram_we_n=0 for all but its last clock.
REQ-022 Write beat k shall drive sram_dq_o = wdata[16k+15:16k]; a byte write replicates wdata[7:0] on both lanes.
REQ-023 Read beat k shall capture sram_dq_i on the last clock of the beat into rdata[16k+15:16k]; a byte read returns the lane chosen by addr[0] in rdata[7:0].
REQ-024 sram_be_n shall be 2'b00 except for byte access: 2'b10 if addr[0]=0, 2'b01 if addr[0]=1.
REQ-025 ext_ack shall rise exactly beats*WAIT_CYCLES+1 clocks after the accepting edge and remain high for one clock.
REQ-026 ext_rdata shall update only when a read completes and hold its value otherwise; writes leave it unchanged.
REQ-027 ext_req high in ACK state shall be ignored; a new request is accepted no earlier than 2 clocks after ack rises, so a held request is never double-acked.
REQ-028 Outside ACCESS: sram_ce_n, sram_oe_n, sram_we_n =1, sram_be_n=2'b11, sram_dq_oe=0.

Reset
REQ-029 While rst_n=0: state IDLE, ext_ack=0, ext_rdata=0, sram_a=0, sram_dq_o=0, sram_dq_oe=0, all strobes and be_n high.
REQ-030 Reset asserted mid-transaction shall abort it immediately, with no ack and no further device cycles.

Configuration
REQ-031 Macro MP64_EXTMEM_RANGE_CHK_EN: if defined, a request with ext_addr[63:ADDR_W] != 0 shall generate no device cycle, go directly to ACK (ack 1 clock after acceptance), return rdata = 64'hFFFF_FFFF_FFFF_FFFF for reads, and drop writes.
REQ-032 Without MP64_EXTMEM_RANGE_CHK_EN, upper address bits shall be ignored and the address shall alias modulo 2^ADDR_W.

Verification
REQ-033 WAIT_CYCLES=2; dword write 0x100 data 0x1122_3344_5566_7788 -> sram_a 0x80..0x83, dq_o 0x7788, 0x5566, 0x3344, 0x1122, be_n=00, ack 9 clocks after acceptance.
REQ-034 Dword read 0x100 with the device model returning the REQ-033 data -> ext_rdata=0x1122_3344_5566_7788 at ack.
REQ-035 Byte read 0x201 with dq_i=0x0708 -> be_n=01, ext_rdata=0x07; half read 0x200 -> 0x0708.
REQ-036 ext_req held high through ack -> exactly one ack per request; next acceptance no earlier than 2 clocks after ack.
REQ-037 rst_n pulsed low during beat 2 of a dword write -> strobes high, dq_oe=0 immediately, no ack; next request completes normally.
REQ-038 With MP64_EXTMEM_RANGE_CHK_EN, read 0x1_0000_0000 -> sram_ce_n stays 1, ack 1 clock after acceptance, rdata all ones; without it, the same read accesses sram_a=0.
